// File: rtl/ram_port_pkg.sv
// Shared constants, helpers and types for the RAM port requester.
package ram_port_pkg;

   localparam int RAM_RD_LATENCY = 1;

   function automatic int addr_bits_for(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic       write;
      logic [7:0] data;
   } rsp_entry_t;

endpackage

// File: rtl/ram_port_requester_if.sv
// Request/response handshake bundle between a client and ram_port_requester.
// RAM_PORT_REQUESTER_WR_ACK_EN adds the rsp_write ack marker.
interface ram_port_requester_if #(
   parameter int ADDR_BITS = 9,
   parameter int WIDTH     = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic [WIDTH-1:0]     req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WIDTH-1:0]     rsp_rdata;
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
   logic                 rsp_write;

   modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_write);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                   output req_ready, rsp_valid, rsp_rdata, rsp_write);
`else
   modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                   input  req_ready, rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                   output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/ram_port_rsp_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; pointers wrap at DEPTH.
module ram_port_rsp_fifo #(
   parameter int  DEPTH = 3,
   parameter int  WIDTH = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));

   // storage, pointers and occupancy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (pop) rd_ptr <= bump(rd_ptr);
         if (push && !pop) count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   ram_port_rsp_fifo_chk u_chk (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .full    (full),
      .empty   (empty)
   );
endmodule

// File: rtl/ram_port_rsp_fifo_chk.sv
// Protocol checks for the response FIFO; the credit rule keeps it from overflowing.
module ram_port_rsp_fifo_chk (
   input logic clock,
   input logic reset_n,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty
);
   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));
   a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) !(pop && empty));
endmodule

// File: rtl/ram_port_requester.sv
// Drives one RAM port from a valid/ready stream and buffers read data behind credits.
// RAM_PORT_REQUESTER_WR_ACK_EN: writes also take a credit and return an in-order echo ack.
module ram_port_requester
   import ram_port_pkg::*;
#(
   parameter int  DEPTH          = 512,
   parameter int  WIDTH          = 8,
   parameter int  RSP_FIFO_DEPTH = 3,
   localparam int ADDR_BITS      = addr_bits_for(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   ram_port_requester_if.slave  bus,
   output logic [ADDR_BITS-1:0] ram_address,
   output logic                 ram_wren,
   output logic [WIDTH-1:0]     ram_data,
   input  logic [WIDTH-1:0]     ram_q
);
   localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
   localparam int L  = RAM_RD_LATENCY;
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
   localparam int FW = WIDTH + 1;
`else
   localparam int FW = WIDTH;
`endif

   logic          ready;
   logic          accept;
   logic          issue_rsp;
   logic          push;
   logic          pop;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW:0]   used_next;
   logic [L-1:0]  vld_pipe;
   logic [FW-1:0] push_data;
   logic [FW-1:0] pop_data;

   assign accept        = bus.req_valid && ready;
   assign bus.req_ready = ready;
   assign ram_address   = reset_n ? bus.req_addr  : '0;
   assign ram_data      = reset_n ? bus.req_wdata : '0;
   assign ram_wren      = accept && bus.req_write;
   assign push          = vld_pipe[L-1];
   assign bus.rsp_valid = !empty;
   assign pop           = !empty && bus.rsp_ready;

`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
   logic [L-1:0]     wr_pipe;
   logic [WIDTH-1:0] wdata_pipe [L];

   assign issue_rsp     = accept;
   assign push_data     = {wr_pipe[L-1], wr_pipe[L-1] ? wdata_pipe[L-1] : ram_q};
   assign bus.rsp_write = pop_data[WIDTH];
   assign bus.rsp_rdata = pop_data[WIDTH-1:0];

   // write flag and echo data ride the read-latency pipe so acks stay in issue order
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_pipe <= '0;
         for (int i = 0; i < L; i++) wdata_pipe[i] <= '0;
      end else begin
         wr_pipe[0]    <= bus.req_write;
         wdata_pipe[0] <= bus.req_wdata;
         for (int i = 1; i < L; i++) begin
            wr_pipe[i]    <= wr_pipe[i-1];
            wdata_pipe[i] <= wdata_pipe[i-1];
         end
      end
   end
`else
   assign issue_rsp     = accept && !bus.req_write;
   assign push_data     = ram_q;
   assign bus.rsp_rdata = pop_data;
`endif

   // credits used after the next edge: buffered entries plus responses still in flight
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end else begin
         count_next = count;
      end
      used_next = {1'b0, count_next} + (CW+1)'(issue_rsp);
      for (int i = 0; i < L - 1; i++) used_next = used_next + (CW+1)'(vld_pipe[i]);
   end

   // ready is purely registered so rsp_ready and req_* never reach it combinationally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready    <= 1'b0;
         vld_pipe <= '0;
      end else begin
         ready       <= (used_next < (CW+1)'(RSP_FIFO_DEPTH));
         vld_pipe[0] <= issue_rsp;
         for (int i = 1; i < L; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   ram_port_rsp_fifo #(
      .DEPTH (RSP_FIFO_DEPTH),
      .WIDTH (FW)
   ) u_rsp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (count),
      .empty     (empty)
   );
endmodule

// File: tb/tb_ram_port_requester.sv
// Scoreboard bench for ram_port_requester: FIFO depth 3 on port A, depth 2 on port B of one RAM.
module tb_ram_port_requester;
   localparam int AW = 9;
   localparam int W  = 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   ram_port_requester_if #(.ADDR_BITS(AW), .WIDTH(W)) bus ();
   ram_port_requester_if #(.ADDR_BITS(AW), .WIDTH(W)) bus2 ();

   logic [AW-1:0] ram_address, ram_address2;
   logic          ram_wren, ram_wren2;
   logic [W-1:0]  ram_data, ram_data2, ram_q, ram_q2;

   ram_port_requester #(.DEPTH(512), .WIDTH(W), .RSP_FIFO_DEPTH(3)) u_dut (
      .clock(clock), .reset_n(reset_n), .bus(bus),
      .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q));

   ram_port_requester #(.DEPTH(512), .WIDTH(W), .RSP_FIFO_DEPTH(2)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2),
      .ram_address(ram_address2), .ram_wren(ram_wren2), .ram_data(ram_data2), .ram_q(ram_q2));

   // dual-port RAM model with registered q
   logic [W-1:0] ram [512];
   always @(posedge clock) begin
      if (ram_wren)  ram[ram_address]  <= ram_data;
      if (ram_wren2) ram[ram_address2] <= ram_data2;
      ram_q  <= ram[ram_address];
      ram_q2 <= ram[ram_address2];
   end

   typedef struct {
      logic [W-1:0] data;
      logic         wr;
      int           cyc;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         exp2_q[$];
   int           rsp_cyc_q[$];
   int           rsp2_cyc_q[$];
   logic [W-1:0] shadow [512];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           n_rsp = 0;
   int           n_rsp2 = 0;
   int           last_lat = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // port A scoreboard: push on accepted request, pop and compare on response
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got rdata=%h with nothing outstanding", bus.rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               last_lat = cyc - e.cyc;
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
               if (bus.rsp_rdata !== e.data || bus.rsp_write !== e.wr || last_lat < 2) begin
                  errors++;
                  $display("FAIL rsp_data: got rdata=%h write=%b lat=%0d, expected rdata=%h write=%b lat>=2",
                           bus.rsp_rdata, bus.rsp_write, last_lat, e.data, e.wr);
               end
`else
               if (bus.rsp_rdata !== e.data || last_lat < 2) begin
                  errors++;
                  $display("FAIL rsp_data: got rdata=%h lat=%0d, expected rdata=%h lat>=2",
                           bus.rsp_rdata, last_lat, e.data);
               end
`endif
            end
            n_rsp++;
            rsp_cyc_q.push_back(cyc);
         end
         if (reset_n && bus.req_valid && bus.req_ready) begin
            if (bus.req_write) begin
               shadow[bus.req_addr] = bus.req_wdata;
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
               exp_q.push_back('{data: bus.req_wdata, wr: 1'b1, cyc: cyc});
`endif
            end else begin
               exp_q.push_back('{data: shadow[bus.req_addr], wr: 1'b0, cyc: cyc});
            end
         end
      end
   end

   // port B scoreboard: expectations are pushed by the streaming task
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n && bus2.rsp_valid && bus2.rsp_ready) begin
            checks++;
            if (exp2_q.size() == 0) begin
               errors++;
               $display("FAIL fifo2_unexpected: got rdata=%h with nothing outstanding", bus2.rsp_rdata);
            end else begin
               e = exp2_q.pop_front();
               if (bus2.rsp_rdata !== e.data) begin
                  errors++;
                  $display("FAIL fifo2_data: got rdata=%h expected %h", bus2.rsp_rdata, e.data);
               end
            end
            n_rsp2++;
            rsp2_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic wr, input int a, input logic [W-1:0] d);
      bus.req_valid = v;
      bus.req_write = wr;
      bus.req_addr  = AW'(a);
      bus.req_wdata = d;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 3, 8'h77);
      bus.rsp_ready  = 1'b1;
      bus2.req_valid = 1'b0;
      bus2.req_write = 1'b0;
      bus2.req_addr  = '0;
      bus2.req_wdata = '0;
      bus2.rsp_ready = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks += 4;
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00", bus.rsp_rdata); end
      if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); end
      drive(1'b0, 1'b0, 0, 8'h00);
      tick();
      reset_n = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checks += 2;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b expected 1", bus.req_ready); end
      if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready2: got %b expected 1", bus2.req_ready); end
   endtask

   task automatic test_write_read();
      int n0;
      int n_exp;
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
      n_exp = 2;
`else
      n_exp = 1;
`endif
      n0 = n_rsp;
      tick(); drive(1'b1, 1'b1, 5, 8'hA5);
      tick(); drive(1'b1, 1'b0, 5, 8'h00);
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         if (n_rsp - n0 >= n_exp) break;
         tick();
      end
      repeat (3) tick();
      checks += 2;
      if (n_rsp - n0 != n_exp) begin errors++; $display("FAIL wr_rd_count: got %0d responses expected %0d", n_rsp - n0, n_exp); end
      if (last_lat != 2) begin errors++; $display("FAIL wr_rd_latency: got %0d cycles expected 2", last_lat); end
   endtask

   task automatic test_preload();
      for (int i = 0; i < 16; i++) begin
         tick(); drive(1'b1, 1'b1, i, 8'(8'h10 + i));
         @(negedge clock);
         checks++;
         if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL preload_ready: addr %0d got %b expected 1", i, bus.req_ready); end
      end
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      repeat (6) tick();
   endtask

   task automatic test_back_to_back();
      rsp_cyc_q.delete();
      for (int i = 0; i < 16; i++) begin
         tick(); drive(1'b1, 1'b0, i, 8'h00);
         @(negedge clock);
         checks++;
         if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: read %0d got %b expected 1", i, bus.req_ready); end
      end
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      repeat (6) tick();
      checks += 2;
      if (rsp_cyc_q.size() != 16) begin
         errors++; $display("FAIL b2b_count: got %0d responses expected 16", rsp_cyc_q.size());
      end else if (rsp_cyc_q[15] - rsp_cyc_q[0] != 15) begin
         errors++; $display("FAIL b2b_rate: got span %0d cycles expected 15", rsp_cyc_q[15] - rsp_cyc_q[0]);
      end
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d outstanding expected 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int n_acc = 0;
      int n0;
      bus.rsp_ready = 1'b0;
      n0 = n_rsp;
      for (int c = 0; c < 6; c++) begin
         tick(); drive(1'b1, 1'b0, n_acc, 8'h00);
         @(negedge clock);
         if (bus.req_ready) n_acc++;
      end
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      checks += 3;
      if (n_acc != 3) begin errors++; $display("FAIL bp_accepts: got %0d expected 3", n_acc); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", bus.req_ready); end
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_held: got %b expected 1", bus.rsp_valid); end
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0 && bus.req_ready) break;
         tick();
      end
      checks += 2;
      if (n_rsp - n0 != 3) begin errors++; $display("FAIL bp_responses: got %0d expected 3", n_rsp - n0); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", bus.req_ready); end
   endtask

   task automatic test_reset_mid();
      int n0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1'b1, 1'b0, i, 8'h00);
      end
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      checks++;
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered: got rsp_valid=%b expected 1", bus.rsp_valid); end
      reset_n = 1'b0;
      #1;
      checks += 2;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready: got %b expected 0", bus.req_ready); end
      exp_q.delete();
      exp2_q.delete();
      n0 = n_rsp;
      repeat (2) tick();
      reset_n = 1'b1;
      bus.rsp_ready = 1'b1;
      repeat (6) tick();
      checks++;
      if (n_rsp != n0) begin errors++; $display("FAIL mid_stale: got %0d responses after release expected 0", n_rsp - n0); end
      drive(1'b1, 1'b0, 5, 8'h00);
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      repeat (6) tick();
      checks += 2;
      if (n_rsp - n0 != 1) begin errors++; $display("FAIL mid_next_read: got %0d responses expected 1", n_rsp - n0); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: got %0d outstanding expected 0", exp_q.size()); end
   endtask

   task automatic test_fifo2_stream();
      int   a = 0;
      logic saw_stall = 1'b0;
      rsp2_cyc_q.delete();
      bus2.rsp_ready = 1'b1;
      for (int c = 0; c < 60 && a < 12; c++) begin
         tick();
         bus2.req_valid = 1'b1;
         bus2.req_addr  = AW'(a);
         @(negedge clock);
         if (bus2.req_ready) begin
            exp2_q.push_back('{data: shadow[a], wr: 1'b0, cyc: cyc});
            a++;
         end else begin
            saw_stall = 1'b1;
         end
      end
      tick(); bus2.req_valid = 1'b0;
      repeat (6) tick();
      checks += 4;
      if (a != 12) begin errors++; $display("FAIL fifo2_issue: got %0d issued expected 12", a); end
      if (saw_stall !== 1'b1) begin errors++; $display("FAIL fifo2_credit: got no stall expected req_ready to drop"); end
      if (n_rsp2 != 12) begin
         errors++; $display("FAIL fifo2_count: got %0d responses expected 12", n_rsp2);
      end else if (rsp2_cyc_q[11] - rsp2_cyc_q[0] > 22) begin
         errors++; $display("FAIL fifo2_rate: got span %0d cycles expected <= 22", rsp2_cyc_q[11] - rsp2_cyc_q[0]);
      end
      if (exp2_q.size() != 0) begin errors++; $display("FAIL fifo2_drain: got %0d outstanding expected 0", exp2_q.size()); end
   endtask

`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
   task automatic test_wr_ack();
      int n0 = n_rsp;
      tick(); drive(1'b1, 1'b1, 7, 8'h3C);
      tick(); drive(1'b1, 1'b0, 7, 8'h00);
      tick(); drive(1'b0, 1'b0, 0, 8'h00);
      repeat (6) tick();
      checks += 2;
      if (n_rsp - n0 != 2) begin errors++; $display("FAIL wr_ack_count: got %0d responses expected 2", n_rsp - n0); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL wr_ack_drain: got %0d outstanding expected 0", exp_q.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_preload();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_fifo2_stream();
`ifdef RAM_PORT_REQUESTER_WR_ACK_EN
      test_wr_ack();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
